// File: rtl/cpu_pkg.sv
// Shared datapath constants: bus width, register indexing and write tags.
// Latency: none (constants only).
// Backpressure: none (constants only).
package cpu_pkg;

    localparam int WORD_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    localparam logic [REG_IDX_W-1:0] PC_IDX = 3'd7;

    typedef logic [3:0] tag_t;

    localparam tag_t TAG_A    = 4'd8;
    localparam tag_t TAG_G    = 4'd9;
    localparam tag_t TAG_NONE = 4'd15;

    // Tag reported for a general-register load of index idx.
    function automatic tag_t reg_tag(input logic [REG_IDX_W-1:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/bus_regfile_if.sv
// Control/data bundle between the control unit (master) and the register file (slave).
// Latency: none (wiring only).
// Backpressure: none; loads are accepted every cycle they are requested.
interface bus_regfile_if #(
    parameter int WORD_W = cpu_pkg::WORD_W
);
    import cpu_pkg::*;

    logic [WORD_W-1:0]    buswires;
    logic                 rin_en;
    logic [REG_IDX_W-1:0] rin;
    logic                 ain;
    logic                 gin;
    logic [WORD_W-1:0]    aluout;
    logic                 incr_pc;

    logic [WORD_W-1:0]    r0, r1, r2, r3, r4, r5, r6, r7;
    logic [WORD_W-1:0]    a_q;
    logic [WORD_W-1:0]    g_q;
    logic                 wr_ack;
    tag_t                 wr_idx;

    modport master (
        output buswires, rin_en, rin, ain, gin, aluout, incr_pc,
        input  r0, r1, r2, r3, r4, r5, r6, r7, a_q, g_q, wr_ack, wr_idx
    );

    modport slave (
        input  buswires, rin_en, rin, ain, gin, aluout, incr_pc,
        output r0, r1, r2, r3, r4, r5, r6, r7, a_q, g_q, wr_ack, wr_idx
    );

endinterface

// File: rtl/reg_en_word.sv
// Single datapath word register with load enable and async reset to RST_VAL.
// Latency: 1 cycle from ld to q.
// Backpressure: none; ld is honoured on every rising edge.
module reg_en_word #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when loaded, otherwise hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= RST_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bus_regfile.sv
// Write-side bus endpoint: loads r0..r7/A from the bus and G from the ALU; r7 is the PC.
// Latency: 1 cycle from load request to register output and to wr_ack/wr_idx.
// Backpressure: none; optional PC auto-increment enabled by macro PC_INCR_EN.
module bus_regfile
    import cpu_pkg::*;
#(
    parameter int                 WORD_W   = cpu_pkg::WORD_W,
    parameter logic [WORD_W-1:0]  PC_RESET = '0
) (
    input  logic        clk,
    input  logic        resetn,
    bus_regfile_if.slave bus
);

    logic [WORD_W-1:0] gr [0:NUM_REGS-2];
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] g_q;
    logic [WORD_W-1:0] pc_q;
    logic              wr_ack_q;
    tag_t              wr_idx_q;

    // r0..r6: plain bus-loaded registers, one-hot enable from rin.
    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_gr
        reg_en_word #(.W(WORD_W), .RST_VAL('0)) u_gr (
            .clk    (clk),
            .resetn (resetn),
            .ld     (bus.rin_en && (bus.rin == REG_IDX_W'(i))),
            .d      (bus.buswires),
            .q      (gr[i])
        );
    end

    reg_en_word #(.W(WORD_W), .RST_VAL('0)) u_a (
        .clk    (clk),
        .resetn (resetn),
        .ld     (bus.ain),
        .d      (bus.buswires),
        .q      (a_q)
    );

    reg_en_word #(.W(WORD_W), .RST_VAL('0)) u_g (
        .clk    (clk),
        .resetn (resetn),
        .ld     (bus.gin),
        .d      (bus.aluout),
        .q      (g_q)
    );

`ifndef PC_INCR_EN
    // Increment request has no effect in this build; port kept for interface stability.
    logic unused_incr_pc;
    assign unused_incr_pc = bus.incr_pc;
`endif

    // r7 / PC: a bus load beats increment; increment wraps modulo 2^WORD_W.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q <= PC_RESET;
        end else if (bus.rin_en && (bus.rin == PC_IDX)) begin
            pc_q <= bus.buswires;
`ifdef PC_INCR_EN
        end else if (bus.incr_pc) begin
            pc_q <= pc_q + WORD_W'(1);
`endif
        end
    end

    // Write acknowledge pulse and tag of the most recent load (rN > G > A).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ack_q <= 1'b0;
            wr_idx_q <= TAG_NONE;
        end else begin
            wr_ack_q <= bus.rin_en | bus.ain | bus.gin;
            if (bus.rin_en) begin
                wr_idx_q <= reg_tag(bus.rin);
            end else if (bus.gin) begin
                wr_idx_q <= TAG_G;
            end else if (bus.ain) begin
                wr_idx_q <= TAG_A;
            end
        end
    end

    assign bus.r0     = gr[0];
    assign bus.r1     = gr[1];
    assign bus.r2     = gr[2];
    assign bus.r3     = gr[3];
    assign bus.r4     = gr[4];
    assign bus.r5     = gr[5];
    assign bus.r6     = gr[6];
    assign bus.r7     = pc_q;
    assign bus.a_q    = a_q;
    assign bus.g_q    = g_q;
    assign bus.wr_ack = wr_ack_q;
    assign bus.wr_idx = wr_idx_q;

endmodule

// File: tb/tb_bus_regfile.sv
// Randomised scoreboard bench for bus_regfile against a register-array reference model.
// Latency: expectations are pushed before each edge and popped one edge later.
// Backpressure: none; the monitor pops one expectation per rising edge.
module tb_bus_regfile;

    localparam logic [15:0] PC_RST = 16'h0010;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    bus_regfile_if #(.WORD_W(16)) bif ();

    bus_regfile #(.WORD_W(16), .PC_RESET(PC_RST)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][15:0] r;
        logic [15:0]      a;
        logic [15:0]      g;
        logic             ack;
        logic [3:0]       idx;
    } snap_t;

    snap_t m;
    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic snap_t reset_snap();
        snap_t s;
        s.r    = '0;
        s.r[7] = PC_RST;
        s.a    = '0;
        s.g    = '0;
        s.ack  = 1'b0;
        s.idx  = 4'd15;
        return s;
    endfunction

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void check_all(input string tag, input snap_t e);
        logic [7:0][15:0] dr;
        dr = {bif.r7, bif.r6, bif.r5, bif.r4, bif.r3, bif.r2, bif.r1, bif.r0};
        for (int i = 0; i < 8; i++) chk($sformatf("%s r%0d", tag, i), dr[i], e.r[i]);
        chk({tag, " a_q"}, bif.a_q, e.a);
        chk({tag, " g_q"}, bif.g_q, e.g);
        chk({tag, " wr_ack"}, {15'd0, bif.wr_ack}, {15'd0, e.ack});
        chk({tag, " wr_idx"}, {12'd0, bif.wr_idx}, {12'd0, e.idx});
    endfunction

    // Reference model: what the register file should hold after one edge.
    function automatic void model_step(input logic re, input logic [2:0] ri, input logic ai,
                                       input logic gi, input logic inc,
                                       input logic [15:0] bw, input logic [15:0] alu);
        snap_t n;
        n = m;
        if (re) n.r[ri] = bw;
`ifdef PC_INCR_EN
        if (inc && !(re && ri == 3'd7)) n.r[7] = m.r[7] + 16'd1;
`else
        if (inc) n.r[7] = n.r[7];
`endif
        if (ai) n.a = bw;
        if (gi) n.g = alu;
        n.ack = re | ai | gi;
        if (re)      n.idx = {1'b0, ri};
        else if (gi) n.idx = 4'd9;
        else if (ai) n.idx = 4'd8;
        m = n;
    endfunction

    task automatic set_in(input logic re, input logic [2:0] ri, input logic ai, input logic gi,
                          input logic inc, input logic [15:0] bw, input logic [15:0] alu);
        bif.rin_en   = re;
        bif.rin      = ri;
        bif.ain      = ai;
        bif.gin      = gi;
        bif.incr_pc  = inc;
        bif.buswires = bw;
        bif.aluout   = alu;
    endtask

    task automatic drive(input logic re, input logic [2:0] ri, input logic ai, input logic gi,
                         input logic inc, input logic [15:0] bw, input logic [15:0] alu);
        @(negedge clk);
        set_in(re, ri, ai, gi, inc, bw, alu);
        model_step(re, ri, ai, gi, inc, bw, alu);
        exp_q.push_back(m);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expectation consumed per rising edge while out of reset.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (resetn && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all("sb", e);
            end
        end
    end

    initial begin
        set_in(0, 0, 0, 0, 0, 16'h0, 16'h0);
        #1 resetn = 1'b0;
        #2;
        m = reset_snap();
        check_all("reset", m);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Single register load.
        drive(1, 3'd3, 0, 0, 0, 16'hA5A5, 16'h0);
        after_edge();
        chk("load r3", bif.r3, 16'hA5A5);
        chk("load r2 held", bif.r2, 16'h0000);
        chk("load ack", {15'd0, bif.wr_ack}, 16'd1);
        chk("load idx", {12'd0, bif.wr_idx}, 16'd3);

        // All three loads in one cycle.
        drive(1, 3'd0, 1, 1, 0, 16'h1234, 16'h00FF);
        after_edge();
        chk("sim r0", bif.r0, 16'h1234);
        chk("sim a", bif.a_q, 16'h1234);
        chk("sim g", bif.g_q, 16'h00FF);
        chk("sim idx", {12'd0, bif.wr_idx}, 16'd0);

        // gin beats ain for the tag.
        drive(0, 3'd0, 1, 1, 0, 16'h4321, 16'h7777);
        after_edge();
        chk("tag g", {12'd0, bif.wr_idx}, 16'd9);
        drive(0, 3'd0, 0, 0, 0, 16'h0, 16'h0);
        after_edge();
        chk("idle ack", {15'd0, bif.wr_ack}, 16'd0);
        chk("idle idx hold", {12'd0, bif.wr_idx}, 16'd9);

`ifdef PC_INCR_EN
        drive(1, 3'd7, 0, 0, 0, 16'h0005, 16'h0);
        drive(1, 3'd7, 0, 0, 1, 16'h0100, 16'h0);
        after_edge();
        chk("pc load beats incr", bif.r7, 16'h0100);
        drive(0, 3'd0, 0, 0, 1, 16'h0, 16'h0);
        after_edge();
        chk("pc incr", bif.r7, 16'h0101);
        chk("pc incr ack", {15'd0, bif.wr_ack}, 16'd0);
`endif

        // PC wrap (or hold when increment is compiled out).
        drive(1, 3'd7, 0, 0, 0, 16'hFFFF, 16'h0);
        drive(0, 3'd0, 0, 0, 1, 16'h0, 16'h0);
        after_edge();
`ifdef PC_INCR_EN
        chk("pc wrap", bif.r7, 16'h0000);
`else
        chk("pc no incr", bif.r7, 16'hFFFF);
`endif
        chk("pc wrap ack", {15'd0, bif.wr_ack}, 16'd0);

        // Reset between edges while a load is pending.
        drive(1, 3'd2, 0, 0, 0, 16'hBEEF, 16'h0);
        after_edge();
        chk("r2 before reset", bif.r2, 16'hBEEF);
        @(negedge clk);
        set_in(1, 3'd2, 0, 0, 0, 16'h1111, 16'h0);
        #2 resetn = 1'b0;
        #1;
        m = reset_snap();
        check_all("midreset", m);
        #1 resetn = 1'b1;
        model_step(1, 3'd2, 0, 0, 0, 16'h1111, 16'h0);
        exp_q.push_back(m);
        after_edge();
        chk("r2 after release", bif.r2, 16'h1111);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
        end
        drive(0, 3'd0, 0, 0, 0, 16'h0, 16'h0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
